// File: rtl/aes_pio_sequencer.sv
// aes_pio_sequencer
// Command sequencer between the HPS PIO pair and an AES core. Commands arrive
// as a toggle request on an 8-bit control PIO. The block assembles the 128-bit
// key and text from 32-bit words, starts the core, and returns result words and
// status on read-only PIO buses.
//
// Handshake: the HPS writes hps_data_in and hps_ctrl_in[7:1], then flips
// hps_ctrl_in[0] (req). A command is pending while the synchronized req
// differs from ack (fpga_status_out[0]). The block executes one pending
// command in IDLE and flips ack when it is complete. A start is acked only
// when the core finishes or times out. The HPS holds data and ctrl stable
// until ack equals req again.
module aes_pio_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_W      = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  hps_data_in,
  input  logic [7:0]   hps_ctrl_in,
  output logic [31:0]  fpga_data_out,
  output logic [7:0]   fpga_status_out,
  output logic [127:0] aes_key,
  output logic [127:0] aes_text,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_result
);

  // A synchronizer shallower than two flops is not safe, so clamp the depth.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [1:0] OP_TEXT  = 2'b00;
  localparam logic [1:0] OP_KEY   = 2'b01;
  localparam logic [1:0] OP_START = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Sequencer state. It is kept as a named enum so checkers can bind to it.
  state_t state;

  logic [SYNC_N-1:0]    req_sync;
  logic                 req_s;
  logic                 ack;
  logic                 busy;
  logic                 result_valid;
  logic                 error;
  logic [3:0]           key_mask;
  logic [3:0]           text_mask;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [127:0]         result_reg;

  logic                 cmd_pending;
  logic [1:0]           cmd_op;
  logic [1:0]           cmd_idx;
  logic [6:0]           word_lsb;
  logic                 masks_full;
  logic                 tmo_expire;
  logic                 unused_ctrl;

  assign req_s       = req_sync[SYNC_N-1];
  assign cmd_pending = (req_s != ack);
  assign cmd_op      = hps_ctrl_in[2:1];
  assign cmd_idx     = hps_ctrl_in[4:3];
  // Word index i covers bits [32*i+31:32*i], so index 0 is the least significant word.
  assign word_lsb    = {cmd_idx, 5'b00000};
  assign masks_full  = (key_mask == 4'hF) && (text_mask == 4'hF);
  // The timeout fires on the cycle the counter steps from 1 to 0. A zero
  // setting disables it entirely.
  assign tmo_expire  = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TIMEOUT_W'(1));
  // The reserved control bits carry no meaning.
  assign unused_ctrl = ^hps_ctrl_in[7:5];

  assign fpga_status_out = {4'b0000, error, result_valid, busy, ack};

  // Bring the asynchronous req toggle into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_N-2:0], hps_ctrl_in[0]};
    end
  end

  // Command FSM. It owns every status, data and core-facing register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      ack           <= 1'b0;
      busy          <= 1'b0;
      result_valid  <= 1'b0;
      error         <= 1'b0;
      key_mask      <= '0;
      text_mask     <= '0;
      tmo_cnt       <= '0;
      result_reg    <= '0;
      aes_key       <= '0;
      aes_text      <= '0;
      aes_start     <= 1'b0;
      fpga_data_out <= '0;
    end else begin
      aes_start <= 1'b0;
      case (state)
        IDLE: begin
          // aes_done is ignored here, so a stray pulse cannot overwrite result_reg.
          if (cmd_pending) begin
            case (cmd_op)
              OP_TEXT: begin
                aes_text[word_lsb +: 32] <= hps_data_in;
                text_mask[cmd_idx]       <= 1'b1;
                result_valid             <= 1'b0;
                ack                      <= ~ack;
              end
              OP_KEY: begin
                aes_key[word_lsb +: 32] <= hps_data_in;
                key_mask[cmd_idx]       <= 1'b1;
                result_valid            <= 1'b0;
                ack                     <= ~ack;
              end
              OP_READ: begin
                fpga_data_out <= result_reg[word_lsb +: 32];
                ack           <= ~ack;
              end
              default: begin
                // OP_START. key_mask is kept, so one key serves many blocks.
                // text_mask is cleared so each start needs fresh text.
                if (masks_full) begin
                  error        <= 1'b0;
                  result_valid <= 1'b0;
                  aes_start    <= 1'b1;
                  busy         <= 1'b1;
                  text_mask    <= '0;
                  tmo_cnt      <= TIMEOUT_W'(TIMEOUT_CYCLES);
                  state        <= BUSY;
                end else begin
                  error <= 1'b1;
                  ack   <= ~ack;
                end
              end
            endcase
          end
        end
        BUSY: begin
          // Commands stay pending here. Completion wins over a timeout in the same cycle.
          if (aes_done) begin
            result_reg   <= aes_result;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            tmo_cnt      <= '0;
            ack          <= ~ack;
            state        <= IDLE;
          end else if (tmo_expire) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            tmo_cnt <= '0;
            ack     <= ~ack;
            state   <= IDLE;
          end else if (TIMEOUT_CYCLES != 0) begin
            tmo_cnt <= tmo_cnt - TIMEOUT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_pio_sequencer.md
Name: aes_pio_sequencer

Overview:
Command sequencer between the HPS-side PIO pair and the AES core.
- The HPS has no strobe over PIOs, so this block uses a toggle req/ack handshake on an 8-bit control PIO.
- It assembles 128-bit key and text from 32-bit words and starts the core.
- It drives result words and status onto the read-only PIO in_port buses.

Parameters:
SYNC_STAGES, 2, synchronizer depth on hps_ctrl_in[0] (req toggle); minimum 2.
TIMEOUT_CYCLES, 4096, max cycles in BUSY waiting for aes_done; 0 disables the timeout.
TIMEOUT_W, 16, width of timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
hps_data_in  in  32  data word from HPS data PIO
hps_ctrl_in  in  8  [0] req toggle, [2:1] opcode (00 load text, 01 load key, 10 start, 11 read result), [4:3] word index, [7:5] reserved/ignored
fpga_data_out  out  32  result word to data PIO in_port
fpga_status_out  out  8  [0] ack toggle, [1] busy, [2] result_valid, [3] error, [7:4] 0
aes_key  out  128  assembled key
aes_text  out  128  assembled plaintext
aes_start  out  1  one-cycle start pulse to core
aes_done  in  1  one-cycle completion pulse from core
aes_result  in  128  core output, valid when aes_done=1

Behaviour:
- Reset is asynchronous, active-low on reset_n; clock is clk.
- Reset values: every output 0, state IDLE, key_mask=0, text_mask=0, timeout counter 0, synchronizer flops 0.
- Word mapping: index i occupies bits [32*i+31:32*i], so index 0 is the LSW.
- req_s is hps_ctrl_in[0] after SYNC_STAGES flops.
- A command is pending when req_s != ack (fpga_status_out[0]).
- hps_data_in and hps_ctrl_in[7:1] are sampled in the cycle the pending command executes. The HPS writes them before flipping req and holds them until ack matches req.
- IDLE, pending command, executed in one cycle:
  - Load text: write word into aes_text, set text_mask[idx], clear result_valid, toggle ack.
  - Load key: write word into aes_key, set key_mask[idx], clear result_valid, toggle ack.
  - Read result: fpga_data_out <= result_reg word idx, toggle ack. Data and ack update in the same edge.
  - Start, both masks 4'hF: clear error, clear result_valid, pulse aes_start for 1 cycle, busy=1, clear text_mask, load timeout counter, go BUSY. Ack is not toggled.
  - Start, either mask incomplete: set error, toggle ack, no aes_start, stay IDLE.
- key_mask persists across starts, so a key is reused until reloaded.
- BUSY: timeout counter decrements each cycle.
  - aes_done=1: result_reg <= aes_result, result_valid=1, busy=0, toggle ack, go IDLE.
  - Counter reaches 0 with TIMEOUT_CYCLES != 0: error=1, busy=0, toggle ack, result_valid stays 0, go IDLE.
  - aes_done and timeout in the same cycle: done wins.
  - Commands arriving during BUSY stay pending and execute in IDLE after the current start is acked. The HPS normally waits for ack, so this only matters for misbehaving software.
- aes_done while IDLE is ignored; result_reg is unchanged.
- Latency: a req toggle at edge N is seen at edge N+SYNC_STAGES. A load or read executes and acks at edge N+SYNC_STAGES+1. aes_start is asserted in the cycle after that same edge.
- aes_key and aes_text stay stable while BUSY; loads cannot execute in BUSY.
- Reset mid-operation returns everything to reset values; the core must be reset in parallel.
- error is sticky until the next accepted start.
- Reserved ctrl bits are ignored.

Test Plan:
1. After reset, status=8'h00 and data=0. Toggle req with opcode 11 idx 0 -> ack toggles at edge N+3, fpga_data_out=0.
2. Load key words 0..3 = 16'h2b7e..., text words 0..3, then start -> exactly one aes_start pulse, busy=1. Core returns done after 10 cycles with result 128'h3925841d02dc09fbdc118597196a0b32 -> status=8'h05, read idx 0 returns 32'h196a0b32.
3. Load 3 text words only, then start -> error=1, ack toggled, no aes_start. Load word 3, then start -> error clears and the run proceeds.
4. TIMEOUT_CYCLES=8 and aes_done never asserted -> ack toggles 8 cycles after start, status bit3=1, bit2=0, busy=0.
5. Flip req again during BUSY with a load-text command -> not executed until done. After done, ack toggles twice in total and the text word is updated.
6. Key reuse: second start after reloading text only -> accepted. Assert reset_n=0 mid-BUSY -> all outputs 0 asynchronously and masks cleared.
